layer_flatten: RTL and testbench



---
 rtl/layer_flatten_if.sv | 35 +++
 rtl/layer_flatten.sv | 201 ++++++++++++++++++++
 tb/tb_layer_flatten.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/layer_flatten_if.sv
// rtl/layer_flatten_if.sv - layer-memory bank port bundle shared by the flatten stage and memory
//
// Purpose: groups the read/write/select signals of one layer-memory bank port.
// Ports (signals):
//   crd       read enable            (master -> slave)
//   caddr_rd  read address, AW bits  (master -> slave)
//   cdata_rd  read data, DW bits     (slave -> master, combinational from caddr_rd)
//   cwr       write enable           (master -> slave)
//   caddr_wr  write address, AW bits (master -> slave)
//   cdata_wr  write data, DW bits    (master -> slave)
//   csel      bank select, 3 bits    (master -> slave)
// Modports: master (block driving the bank), slave (memory side).

interface layer_flatten_if #(
    parameter int AW = 12,
    parameter int DW = 20
);
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    modport master (
        output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        input  cdata_rd
    );

    modport slave (
        input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        output cdata_rd
    );
endinterface

// File: rtl/layer_flatten.sv
// rtl/layer_flatten.sv - interleaves two layer-1 maps into the flattened layer-2 vector
//
// Purpose: reads kernel-0 and kernel-1 layer-1 maps entry by entry and writes
// layer 2 with kernel-0 data at even addresses and kernel-1 data at odd
// addresses. Fixed 4-cycle schedule per entry (RD0, RD1, WR0, WR1), no stalls.
// Optional feature macro: FLATTEN_CHECKSUM_EN builds a 32-bit running sum of
// all written values; without it checksum is tied to zero.
// Ports:
//   clk       clock, rising edge
//   reset     synchronous reset, active high
//   start     one-cycle request to begin a pass (honoured only in IDLE)
//   busy      high from the cycle after start is accepted through DONE
//   done      one-cycle pulse in the DONE state
//   checksum  sum of written values (FLATTEN_CHECKSUM_EN), else 0
//   mem       layer-memory bank port (master modport)

module layer_flatten #(
    parameter int       N_ENTRIES = 1024,
    parameter int       AW        = 12,
    parameter int       DW        = 20,
    parameter bit [2:0] SEL_SRC0  = 3'b011,
    parameter bit [2:0] SEL_SRC1  = 3'b100,
    parameter bit [2:0] SEL_DST   = 3'b101
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            checksum,
    layer_flatten_if.master        mem
);

    localparam int          IW   = $clog2(N_ENTRIES);
    localparam logic [IW-1:0] LAST = IW'(N_ENTRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_WR0  = 3'd3,
        S_WR1  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  i_q, i_d;
    logic [DW-1:0]  buf0_q, buf0_d;
    logic [DW-1:0]  buf1_q, buf1_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           crd_q, crd_d;
    logic           cwr_q, cwr_d;
    logic [AW-1:0]  caddr_rd_q, caddr_rd_d;
    logic [AW-1:0]  caddr_wr_q, caddr_wr_d;
    logic [DW-1:0]  cdata_wr_q, cdata_wr_d;
    logic [2:0]     csel_q, csel_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and entry index
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD0;
                    i_d     = '0;
                end
            end
            S_RD0:  state_d = S_RD1;
            S_RD1:  state_d = S_WR0;
            S_WR0:  state_d = S_WR1;
            S_WR1: begin
                if (i_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD0;
                    i_d     = i_q + IW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each strobe,
    // address and select is valid for exactly the cycle its state occupies.
    always_comb begin
        buf0_d     = (state_q == S_RD0) ? mem.cdata_rd : buf0_q;
        buf1_d     = (state_q == S_RD1) ? mem.cdata_rd : buf1_q;
        busy_d     = (state_d != S_IDLE);
        done_d     = 1'b0;
        crd_d      = 1'b0;
        cwr_d      = 1'b0;
        caddr_rd_d = '0;
        caddr_wr_d = '0;
        cdata_wr_d = '0;
        csel_d     = 3'b000;
        case (state_d)
            S_RD0: begin
                crd_d      = 1'b1;
                csel_d     = SEL_SRC0;
                caddr_rd_d = AW'(i_d);
            end
            S_RD1: begin
                crd_d      = 1'b1;
                csel_d     = SEL_SRC1;
                caddr_rd_d = AW'(i_d);
            end
            S_WR0: begin
                // buf0 was captured at the end of RD0 and is stable here
                cwr_d      = 1'b1;
                csel_d     = SEL_DST;
                caddr_wr_d = AW'({i_d, 1'b0});
                cdata_wr_d = buf0_q;
            end
            S_WR1: begin
                cwr_d      = 1'b1;
                csel_d     = SEL_DST;
                caddr_wr_d = AW'({i_d, 1'b1});
                cdata_wr_d = buf1_q;
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_q        <= '0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            csel_q     <= 3'b000;
        end else begin
            i_q        <= i_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
        end
    end

`ifdef FLATTEN_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    // Accumulates the value on the write port during each write cycle, so the
    // final WR1 lands at the edge entering DONE and holds until the next start.
    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && start) begin
            checksum_d = '0;
        end else if (cwr_q) begin
            checksum_d = checksum_q + 32'(cdata_wr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'd0;
`endif

    assign busy         = busy_q;
    assign done         = done_q;
    assign mem.crd      = crd_q;
    assign mem.cwr      = cwr_q;
    assign mem.caddr_rd = caddr_rd_q;
    assign mem.caddr_wr = caddr_wr_q;
    assign mem.cdata_wr = cdata_wr_q;
    assign mem.csel     = csel_q;

endmodule

// File: tb/tb_layer_flatten.sv
// tb/tb_layer_flatten.sv - scoreboard bench for layer_flatten

module tb_layer_flatten;

    localparam int AW = 12;
    localparam int DW = 20;
    localparam int N  = 1024;
`ifdef FLATTEN_CHECKSUM_EN
    localparam logic [31:0] EXP_SUM = 32'h200F_FC00;
`else
    localparam logic [31:0] EXP_SUM = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    layer_flatten_if #(.AW(AW), .DW(DW)) mem_if ();

    layer_flatten #(
        .N_ENTRIES(N), .AW(AW), .DW(DW),
        .SEL_SRC0(3'b011), .SEL_SRC1(3'b100), .SEL_DST(3'b101)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .busy(busy),
        .done(done),
        .checksum(checksum),
        .mem(mem_if)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] src0 [N];
    logic [DW-1:0] src1 [N];
    int            wr_pass [4096];
    int            pass_id = 0;

    assign mem_if.cdata_rd = (mem_if.csel == 3'b011) ? src0[mem_if.caddr_rd[9:0]] :
                             (mem_if.csel == 3'b100) ? src1[mem_if.caddr_rd[9:0]] : '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];
    int  busy_q[$];

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    logic busy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: protocol rules every cycle, scoreboard pops on write/done/busy edges
    always @(negedge clk) begin
        wr_t e;
        check("proto_rd_wr_excl", 64'(mem_if.crd & mem_if.cwr), 64'd0);
        if (mem_if.cwr) check("proto_wr_sel", 64'(mem_if.csel), 64'h5);
        if (mem_if.crd)
            check("proto_rd_sel", 64'(mem_if.csel == 3'b011 || mem_if.csel == 3'b100), 64'd1);
        if (mem_if.cwr) begin
            wr_pass[mem_if.caddr_wr] = pass_id;
            if (wr_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write actual_addr=%0h required=none", mem_if.caddr_wr);
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", 64'(mem_if.caddr_wr), 64'(e.addr));
                check("wr_data", 64'(mem_if.cdata_wr), 64'(e.data));
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done actual_cycle=%0d required=none", cyc);
            end else begin
                check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
                check("checksum_at_done", 64'(checksum), 64'(EXP_SUM));
            end
        end
        if (busy !== busy_prev) begin
            if (busy_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_busy_edge actual_cycle=%0d required=none", cyc);
            end else begin
                check("busy_edge_cycle", 64'(cyc), 64'(busy_q.pop_front()));
            end
        end
        busy_prev = busy;
    end

    // Expected responses for a full pass whose start is sampled at edge s
    task automatic expect_pass(input int s);
        for (int k = 0; k < N; k++) begin
            wr_q.push_back('{addr: AW'(2*k),     data: DW'(k)});
            wr_q.push_back('{addr: AW'(2*k + 1), data: DW'(20'h80000 | k)});
        end
        done_q.push_back(s + 4*N);
        busy_q.push_back(s);
        busy_q.push_back(s + 4*N + 1);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        check(name, 64'(wr_q.size() + done_q.size() + busy_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ctrl"}, 64'({busy, done, mem_if.crd, mem_if.cwr, mem_if.csel}), 64'd0);
        check({name, "_addr_data"}, 64'({mem_if.caddr_rd, mem_if.caddr_wr, mem_if.cdata_wr}), 64'd0);
        check({name, "_checksum"}, 64'(checksum), 64'd0);
    endtask

    initial begin
        int s;
        int bad;
        reset = 1'b1;
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            src0[k] = DW'(k);
            src1[k] = DW'(20'h80000 | k);
        end

        // Reset then idle
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check_idle_outputs("idle");
        end

        // Full pass
        pass_id = 1;
        s = cyc + 1;
        expect_pass(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(s + 4*N + 8);
        check_drained("full_pass_drained");

        // Start pulsed again at cycle 100 of a pass: ignored
        pass_id = 2;
        s = cyc + 1;
        expect_pass(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(s + 100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(s + 4*N + 8);
        check_drained("start_busy_drained");

        // Start held across DONE: new pass only from IDLE
        pass_id = 3;
        s = cyc + 1;
        expect_pass(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(s + 4*N - 1);
        start = 1'b1;
        expect_pass(s + 4*N + 2);
        wait_cyc(s + 4*N + 2);
        start = 1'b0;
        wait_cyc(s + 8*N + 10);
        check_drained("held_start_drained");

        // Reset during WR1 of i=10
        pass_id = 4;
        s = cyc + 1;
        for (int a = 0; a < 22; a++)
            wr_q.push_back('{addr: AW'(a), data: (a % 2 == 0) ? DW'(a/2) : DW'(20'h80000 | (a/2))});
        busy_q.push_back(s);
        busy_q.push_back(s + 44);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(s + 43);
        check("wr1_i10_addr", 64'(mem_if.caddr_wr), 64'd21);
        reset = 1'b1;
        @(negedge clk);
        check("abort_strobes", 64'({mem_if.crd, mem_if.cwr}), 64'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_idle_outputs("after_abort");
        check_drained("abort_drained");
        bad = 0;
        for (int a = 0; a < 4096; a++)
            if ((wr_pass[a] == 4) != (a < 22)) bad++;
        check("abort_dst_extent", 64'(bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
